// File: rtl/aes_pkg.sv
// Shared definitions for the AES SPI front end: FSM states, block width and
// the key-width legality check.
package aes_pkg;

    localparam int unsigned BLOCK_W = 128;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWait,
        StSend,
        StDone
    } aes_state_e;

    function automatic bit key_w_legal(int unsigned n);
        return (n == 128) || (n == 192) || (n == 256);
    endfunction

endpackage

// File: rtl/aes_bit_shifter.sv
// Indexed bit register: single-bit writes at an index (serial-to-parallel),
// full parallel load, and single-bit reads at an index (parallel-to-serial).
module aes_bit_shifter #(
    parameter int unsigned Width = 128,
    parameter int unsigned IdxW  = $clog2(Width)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IdxW-1:0]  wr_idx,
    input  logic             wr_bit,
    input  logic             ld_en,
    input  logic [Width-1:0] ld_data,
    input  logic [IdxW-1:0]  rd_idx,
    output logic             rd_bit,
    output logic [Width-1:0] data,
    output logic [Width-1:0] data_next
);

    logic [Width-1:0] data_q, data_d;

    // Parallel load wins over a bit write; callers never assert both.
    always_comb begin
        data_d = data_q;
        if (ld_en) begin
            data_d = ld_data;
        end else if (wr_en) begin
            data_d[wr_idx] = wr_bit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign rd_bit    = data_q[rd_idx];
    assign data      = data_q;
    assign data_next = data_d;

endmodule

// File: rtl/aes_spi_frontend.sv
// Serial front end for an AES core: collects a block+key frame LSB first,
// starts the core, then streams the 128-bit result back out LSB first.
module aes_spi_frontend
    import aes_pkg::*;
#(
    parameter int unsigned N = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               cs_n,
    input  logic               mosi,
    output logic               miso,
    output logic               miso_valid,
    output logic               busy,
    output logic               frame_err,
    output logic               core_start,
    output logic [BLOCK_W-1:0] core_block,
    output logic [N-1:0]       core_key,
    input  logic               core_done,
    input  logic [BLOCK_W-1:0] core_result
);

    localparam int unsigned FrameW    = BLOCK_W + N;
    localparam int unsigned CntW      = $clog2(FrameW + 1);
    localparam int unsigned FrameIdxW = $clog2(FrameW);
    localparam int unsigned ResIdxW   = $clog2(BLOCK_W);
    localparam logic [CntW-1:0] FrameLast = CntW'(FrameW - 1);
    localparam logic [CntW-1:0] ResLast   = CntW'(BLOCK_W - 1);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);
    localparam bit NLegal = key_w_legal(N);

    aes_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic frame_err_q, frame_err_d;
    logic [BLOCK_W-1:0] block_q;
    logic [N-1:0] key_q;

    logic frame_wr, frame_commit, result_ld;
    logic [FrameIdxW-1:0] frame_idx;
    logic [FrameW-1:0] frame_data, frame_next;
    logic frame_rd_bit;
    logic [BLOCK_W-1:0] result_data, result_next;
    logic result_bit;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        frame_err_d  = frame_err_q;
        frame_wr     = 1'b0;
        frame_commit = 1'b0;
        result_ld    = 1'b0;
        if (enable) begin
            unique case (state_q)
                StIdle: begin
                    if (!cs_n) begin
                        frame_wr    = 1'b1;
                        cnt_d       = CntOne;
                        frame_err_d = 1'b0;
                        state_d     = StLoad;
                    end
                end
                StLoad: begin
                    if (cs_n) begin
                        frame_err_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = StIdle;
                    end else begin
                        frame_wr = 1'b1;
                        cnt_d    = cnt_q + CntOne;
                        if (cnt_q == FrameLast) begin
                            frame_commit = 1'b1;
                            state_d      = StStart;
                        end
                    end
                end
                StStart: state_d = StWait;
                StWait: begin
                    if (core_done) begin
                        result_ld = 1'b1;
                        cnt_d     = '0;
                        state_d   = StSend;
                    end
                end
                StSend: begin
                    if (!cs_n) begin
                        cnt_d = cnt_q + CntOne;
                        if (cnt_q == ResLast) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    // Wait for the frame to close so one frame never triggers twice.
                    if (cs_n) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Core operands are taken from the frame including the bit captured this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            block_q <= '0;
            key_q   <= '0;
        end else if (frame_commit) begin
            block_q <= frame_next[BLOCK_W-1:0];
            key_q   <= frame_next[FrameW-1:BLOCK_W];
        end
    end

    assign frame_idx = (state_q == StIdle) ? '0 : cnt_q[FrameIdxW-1:0];

    aes_bit_shifter #(
        .Width (FrameW),
        .IdxW  (FrameIdxW)
    ) u_frame (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (frame_wr),
        .wr_idx    (frame_idx),
        .wr_bit    (mosi),
        .ld_en     (1'b0),
        .ld_data   ('0),
        .rd_idx    ('0),
        .rd_bit    (frame_rd_bit),
        .data      (frame_data),
        .data_next (frame_next)
    );

    aes_bit_shifter #(
        .Width (BLOCK_W),
        .IdxW  (ResIdxW)
    ) u_result (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (1'b0),
        .wr_idx    ('0),
        .wr_bit    (1'b0),
        .ld_en     (result_ld),
        .ld_data   (core_result),
        .rd_idx    (cnt_q[ResIdxW-1:0]),
        .rd_bit    (result_bit),
        .data      (result_data),
        .data_next (result_next)
    );

    logic unused_sink;
    assign unused_sink = ^{frame_data, frame_rd_bit, result_data, result_next};

    assign miso       = (state_q == StSend) ? result_bit : 1'b0;
    assign miso_valid = (state_q == StSend);
    assign busy       = (state_q != StIdle);
    assign frame_err  = frame_err_q;
    assign core_start = enable && (state_q == StStart);
    assign core_block = block_q;
    assign core_key   = key_q;

    assert property (@(posedge clk) NLegal);

endmodule

// File: tb/tb_aes_spi_frontend.sv
// Directed bench for aes_spi_frontend: table-driven full frames on an N=128
// instance plus hand sequences for abort, reset, stray core_done and N=256.
module tb_aes_spi_frontend;

    localparam logic [127:0] FipsBlock = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FipsKey   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FipsCt    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] Key256    =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;
    logic miso, miso_valid, busy, frame_err, core_start, core_done;
    logic [127:0] core_block, core_key, core_result;

    logic cs_n2 = 1'b1;
    logic mosi2 = 1'b0;
    logic miso2, miso_valid2, busy2, frame_err2, core_start2;
    logic [127:0] core_block2;
    logic [255:0] core_key2;

    always #5 clk = ~clk;

    aes_spi_frontend #(.N(128)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_valid  (miso_valid),
        .busy        (busy),
        .frame_err   (frame_err),
        .core_start  (core_start),
        .core_block  (core_block),
        .core_key    (core_key),
        .core_done   (core_done),
        .core_result (core_result)
    );

    aes_spi_frontend #(.N(256)) dut256 (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cs_n        (cs_n2),
        .mosi        (mosi2),
        .miso        (miso2),
        .miso_valid  (miso_valid2),
        .busy        (busy2),
        .frame_err   (frame_err2),
        .core_start  (core_start2),
        .core_block  (core_block2),
        .core_key    (core_key2),
        .core_done   (1'b0),
        .core_result ('0)
    );

    // Stub core: answers 10 cycles after core_start with stub_result.
    logic [127:0] stub_result = FipsCt;
    logic [127:0] junk_result = {4{32'hbadc0de5}};
    logic stub_done;
    logic manual_done = 1'b0;
    logic [3:0] stub_cnt;
    int starts = 0;

    assign core_done   = stub_done | manual_done;
    assign core_result = stub_done ? stub_result : junk_result;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            stub_cnt  <= 4'd0;
            stub_done <= 1'b0;
        end else begin
            stub_done <= (stub_cnt == 4'd1);
            if (core_start) stub_cnt <= 4'd10;
            else if (stub_cnt != 4'd0) stub_cnt <= stub_cnt - 4'd1;
        end
    end

    always @(posedge clk) if (core_start) starts <= starts + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives frame bits on falling edges; the last bit is sampled on the next rising edge.
    task automatic send_frame(input logic [255:0] frame, input int nbits, input int freeze_at,
                              input int done_at);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            if (i == freeze_at) begin
                enable = 1'b0;
                mosi = ~frame[i];
                repeat (5) @(negedge clk);
                enable = 1'b1;
            end
            manual_done = (i == done_at);
            cs_n = 1'b0;
            mosi = frame[i];
        end
    endtask

    task automatic read_result(input int freeze_at, output logic [127:0] r);
        int guard;
        guard = 0;
        r = '0;
        @(negedge clk);
        manual_done = 1'b0;
        while (!miso_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("miso_valid rises", 256'(miso_valid), 256'(1));
        for (int i = 0; i < 128; i++) begin
            if (i == freeze_at) begin
                enable = 1'b0;
                mosi = ~mosi;
                repeat (5) @(negedge clk);
                enable = 1'b1;
            end
            r[i] = miso;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [127:0] block;
        logic [127:0] key;
        logic [127:0] result;
        int           load_freeze;
        int           send_freeze;
    } vec_t;

    vec_t vecs[3];
    logic [127:0] rd;
    logic [383:0] frame2;
    int snap;
    bit send_seen;

    initial begin
        vecs[0] = '{FipsBlock, FipsKey, FipsCt, -1, -1};
        vecs[1] = '{{8{16'hffff}}, {8{16'h5555}}, 128'h0123456789abcdeffedcba9876543210, 60, 77};
        vecs[2] = '{128'h80000000000000000000000000000001, {4{32'hdeadbeef}},
                    128'hf0000000000000000000000000000003, 255, 0};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst miso", 256'(miso), 256'(0));
        check("rst miso_valid", 256'(miso_valid), 256'(0));
        check("rst busy", 256'(busy), 256'(0));
        check("rst frame_err", 256'(frame_err), 256'(0));
        check("rst core_start", 256'(core_start), 256'(0));
        check("rst core_block", 256'(core_block), 256'(0));
        check("rst core_key", 256'(core_key), 256'(0));
        reset = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        // Frame aborted after 50 bits
        snap = starts;
        send_frame({FipsKey, FipsBlock}, 50, -1, -1);
        @(negedge clk);
        check("abort busy in load", 256'(busy), 256'(1));
        cs_n = 1'b1;
        @(negedge clk);
        check("abort frame_err", 256'(frame_err), 256'(1));
        check("abort idle", 256'(busy), 256'(0));
        check("abort core_block kept", 256'(core_block), 256'(0));
        repeat (3) @(negedge clk);
        check("abort no start", 256'(starts - snap), 256'(0));

        for (int v = 0; v < 3; v++) begin
            stub_result = vecs[v].result;
            snap = starts;
            send_frame({vecs[v].key, vecs[v].block}, 256, vecs[v].load_freeze, -1);
            @(negedge clk);
            check($sformatf("v%0d core_start", v), 256'(core_start), 256'(1));
            check($sformatf("v%0d core_block", v), 256'(core_block), 256'(vecs[v].block));
            check($sformatf("v%0d core_key", v), 256'(core_key), 256'(vecs[v].key));
            check($sformatf("v%0d frame_err", v), 256'(frame_err), 256'(0));
            read_result(vecs[v].send_freeze, rd);
            check($sformatf("v%0d result", v), 256'(rd), 256'(vecs[v].result));
            check($sformatf("v%0d done busy", v), 256'(busy), 256'(1));
            check($sformatf("v%0d done miso_valid", v), 256'(miso_valid), 256'(0));
            cs_n = 1'b1;
            @(negedge clk);
            check($sformatf("v%0d idle", v), 256'(busy), 256'(0));
            check($sformatf("v%0d one start", v), 256'(starts - snap), 256'(1));
        end

        // Stray core_done during LOAD, then cs_n held low through DONE
        stub_result = FipsCt;
        snap = starts;
        send_frame({FipsKey, FipsBlock}, 256, -1, 100);
        @(negedge clk);
        check("stray core_start", 256'(core_start), 256'(1));
        read_result(-1, rd);
        check("stray result", 256'(rd), 256'(FipsCt));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mosi = ~mosi;
        end
        check("hold done busy", 256'(busy), 256'(1));
        check("hold done no send", 256'(miso_valid), 256'(0));
        check("hold done one start", 256'(starts - snap), 256'(1));
        cs_n = 1'b1;
        @(negedge clk);
        check("hold release idle", 256'(busy), 256'(0));

        // N=256: core_start one cycle after bit 383
        frame2 = {Key256, FipsBlock};
        for (int i = 0; i < 384; i++) begin
            @(negedge clk);
            if (i == 383) check("n256 no early start", 256'(core_start2), 256'(0));
            cs_n2 = 1'b0;
            mosi2 = frame2[i];
        end
        @(negedge clk);
        check("n256 core_start", 256'(core_start2), 256'(1));
        check("n256 core_key", core_key2, Key256);
        check("n256 core_block", 256'(core_block2), 256'(FipsBlock));
        @(negedge clk);
        cs_n2 = 1'b1;
        check("n256 start one cycle", 256'(core_start2), 256'(0));
        check("n256 busy wait", 256'(busy2), 256'(1));
        check("n256 no send", 256'(miso_valid2), 256'(0));
        check("n256 miso low", 256'(miso2), 256'(0));
        check("n256 frame_err", 256'(frame_err2), 256'(0));

        // Reset while waiting on the core, then core_done pulses
        snap = starts;
        send_frame({FipsKey, FipsBlock}, 256, -1, -1);
        @(negedge clk);
        check("rstwait core_start", 256'(core_start), 256'(1));
        repeat (3) @(negedge clk);
        check("rstwait busy", 256'(busy), 256'(1));
        reset = 1'b1;
        cs_n = 1'b1;
        @(negedge clk);
        manual_done = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        manual_done = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        send_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (miso_valid) send_seen = 1'b1;
        end
        check("rstwait no send", 256'(send_seen), 256'(0));
        check("rstwait busy", 256'(busy), 256'(0));
        check("rstwait miso", 256'(miso), 256'(0));
        check("rstwait frame_err", 256'(frame_err), 256'(0));
        check("rstwait core_start", 256'(core_start), 256'(0));
        check("rstwait core_block", 256'(core_block), 256'(0));
        check("rstwait core_key", 256'(core_key), 256'(0));
        check("rstwait one start", 256'(starts - snap), 256'(1));
        check("rstwait n256 idle", 256'(busy2), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/aes_spi_frontend.md
AES_SPI_FRONTEND -- requirements
Module: aes_spi_frontend

Interface
REQ-001 SHALL have parameter N, default 128, meaning key width in bits (legal values 128, 192, 256).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port enable  input  1  global advance qualifier; low freezes all state.
REQ-005 SHALL have port cs_n  input  1  serial frame select, active-low.
REQ-006 SHALL have port mosi  input  1  serial data in, LSB first.
REQ-007 SHALL have port miso  output  1  serial result out, LSB first.
REQ-008 SHALL have port miso_valid  output  1  high while miso carries a valid result bit.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port frame_err  output  1  sticky flag: frame aborted during LOAD.
REQ-011 SHALL have port core_start  output  1  one-cycle start pulse to AES core.
REQ-012 SHALL have port core_block  output  128  plaintext/ciphertext block to core.
REQ-013 SHALL have port core_key  output  N  key to core.
REQ-014 SHALL have port core_done  input  1  core completion pulse/level.
REQ-015 SHALL have port core_result  input  128  core output block, valid when core_done high.

Function
REQ-016 SHALL implement states IDLE, LOAD, START, WAIT, SEND, DONE; no transition or shift occurs when enable is low.
REQ-017 IDLE: on enable & !cs_n, SHALL capture mosi into bit 0, set bit counter to 1, clear frame_err, go to LOAD.
REQ-018 LOAD: each cycle with !cs_n, SHALL write mosi into frame bit at counter index and increment; frame bits 0..127 = block, 128..128+N-1 = key.
REQ-019 LOAD: after bit 128+N-1 captured, SHALL go to START the next cycle; core_block/core_key update from frame register at that point.
REQ-020 LOAD with cs_n high: SHALL set frame_err, clear counter, go to IDLE; core_block/core_key unchanged.
REQ-021 START: SHALL assert core_start for exactly one cycle, go to WAIT.
REQ-022 core_block and core_key SHALL remain stable from START until next START.
REQ-023 WAIT: on core_done high, SHALL latch core_result into result register, clear counter, go to SEND; cs_n ignored in WAIT.
REQ-024 SEND: miso SHALL equal result bit [counter] with miso_valid high; counter increments each cycle with !cs_n, holds when cs_n high.
REQ-025 SEND: after bit 127 presented and shifted, SHALL go to DONE; miso_valid low outside SEND.
REQ-026 DONE: SHALL return to IDLE only after cs_n observed high (prevents re-triggering within same frame).
REQ-027 core_done asserted outside WAIT SHALL be ignored.
REQ-028 Frame counter SHALL be clog2(128+N+1) bits wide; no wrap in any state.

Reset
REQ-029 On reset, state SHALL become IDLE; counter, frame, result registers cleared to 0.
REQ-030 Reset values: miso 0, miso_valid 0, busy 0, frame_err 0, core_start 0, core_block 0, core_key 0.
REQ-031 Reset mid-LOAD, WAIT or SEND SHALL abandon the operation with no core_start pulse issued afterwards.

Structure
REQ-032 Shared package aes_pkg SHALL hold state enum, BLOCK_W = 128, and legal-N check constant.
REQ-033 One sub-module aes_bit_shifter (indexed serial-to-parallel / parallel-to-serial register) SHALL be instantiated for frame and result paths.

Verification
REQ-034 N=128, FIPS-197 frame block 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, stub core returns 69c4e0d86a7b0430d8cdb78070b4c55a after 10 cycles -> single core_start, core_block/key match, 128 miso bits reassemble to 69c4...c55a.
REQ-035 N=256, 384-bit frame, key 000102...1f -> core_key matches exactly, core_start one cycle after bit 383 sampled.
REQ-036 cs_n raised after 50 bits -> frame_err 1, IDLE, no core_start; next full frame clears frame_err and completes.
REQ-037 enable low 5 cycles mid-LOAD and mid-SEND -> counter frozen, no lost or duplicated bits, identical result.
REQ-038 reset asserted in WAIT, then core_done pulses -> all outputs at reset values, no SEND entered.
REQ-039 core_done pulsed during LOAD and held cs_n low through DONE -> pulse ignored; no second frame until cs_n high.
